// File: rtl/dynamixel_status_receiver.sv
// Dynamixel Protocol 2.0 status packet receiver.
// An 8N1 UART sampler delivers bytes to a parser that walks the packet
// header, ID, length, instruction (0x55), error, parameters and CRC-16,
// destuffs parameter bytes and reports good packets, CRC mismatches and
// framing problems as one-cycle strobes.
//
// Strobe semantics: status_valid, crc_error and frame_error are single-cycle
// pulses with no ready/backpressure; the consumer must sample them every
// cycle. The status_* fields are stable from a status_valid pulse until the
// next one (or reset).
module dynamixel_status_receiver #(
  parameter int clocks_per_bit = 3,
  parameter int max_length     = 64,
  parameter int timeout_bits   = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        status_valid,
  output logic [7:0]  status_id,
  output logic [7:0]  status_error,
  output logic [15:0] status_param_len,
  output logic [31:0] status_data,
  output logic        crc_error,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [15:0] CPB_M1     = 16'(clocks_per_bit - 1);
  localparam logic [15:0] HALF_M1    = 16'(clocks_per_bit / 2 - 1);
  localparam logic [31:0] TIMEOUT_M1 = 32'(timeout_bits * clocks_per_bit - 1);
  localparam logic [15:0] MAX_LEN    = 16'(max_length);

  typedef enum logic [2:0] {
    U_IDLE, U_START, U_DATA, U_STOP, U_WAIT
  } uart_state_t;

  typedef enum logic [3:0] {
    P_HDR1, P_HDR2, P_HDR3, P_RSV, P_ID, P_LEN_L, P_LEN_H,
    P_INST, P_ERR, P_PARAM, P_CRC_L, P_CRC_H
  } parser_state_t;

  // One byte of CRC-16/0x8005, MSB first, no reflection.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
    end
    return r;
  endfunction

  // ---------------- UART sampler ----------------
  uart_state_t u_state, u_state_n;
  logic [15:0] u_cnt, u_cnt_n;
  logic [2:0]  u_bit, u_bit_n;
  logic [7:0]  u_shift, u_shift_n;
  logic        rx_meta, rx_s, rx_d;
  logic        byte_valid, byte_valid_n;
  logic        stop_err, stop_err_n;
  logic [7:0]  byte_data;

  assign byte_data = u_shift;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // UART state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      u_state    <= U_IDLE;
      u_cnt      <= 16'd0;
      u_bit      <= 3'd0;
      u_shift    <= 8'd0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      u_state    <= u_state_n;
      u_cnt      <= u_cnt_n;
      u_bit      <= u_bit_n;
      u_shift    <= u_shift_n;
      byte_valid <= byte_valid_n;
      stop_err   <= stop_err_n;
    end
  end

  // UART next state: mid-start recheck, 8 data bits LSB first, stop check.
  always_comb begin
    u_state_n    = u_state;
    u_cnt_n      = u_cnt + 16'd1;
    u_bit_n      = u_bit;
    u_shift_n    = u_shift;
    byte_valid_n = 1'b0;
    stop_err_n   = 1'b0;
    case (u_state)
      U_IDLE: begin
        u_cnt_n = 16'd0;
        if (rx_d && !rx_s) u_state_n = U_START;
      end
      U_START: begin
        if (u_cnt == HALF_M1) begin
          u_cnt_n   = 16'd0;
          u_bit_n   = 3'd0;
          u_state_n = rx_s ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (u_cnt == CPB_M1) begin
          u_cnt_n   = 16'd0;
          u_shift_n = {rx_s, u_shift[7:1]};
          u_bit_n   = u_bit + 3'd1;
          if (u_bit == 3'd7) u_state_n = U_STOP;
        end
      end
      U_STOP: begin
        if (u_cnt == CPB_M1) begin
          u_cnt_n = 16'd0;
          if (rx_s) begin
            byte_valid_n = 1'b1;
            u_state_n    = U_IDLE;
          end else begin
            stop_err_n = 1'b1;
            u_state_n  = U_WAIT;
          end
        end
      end
      U_WAIT: begin
        u_cnt_n = 16'd0;
        if (rx_s) u_state_n = U_IDLE;
      end
      default: u_state_n = U_IDLE;
    endcase
  end

  // ---------------- Packet parser ----------------
  parser_state_t p_state, p_state_n;
  logic [31:0] to_cnt;
  logic        timeout_hit;
  logic [7:0]  len_l, id_l, err_l, crc_lo;
  logic [15:0] len, remain, plen_l, crc;
  logic [15:0] len_full;
  logic [31:0] data_l;
  logic [23:0] hist;
  logic        is_stuff;
  logic        good_n, crcbad_n, frame_n;

  assign len_full    = {byte_data, len_l};
  assign timeout_hit = (p_state != P_HDR1) && (to_cnt == TIMEOUT_M1);
  assign is_stuff    = (hist == 24'hFFFFFD) && (byte_data == 8'hFD);
  assign busy        = (p_state >= P_ID);

  // Parser state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) p_state <= P_HDR1;
    else       p_state <= p_state_n;
  end

  // Parser next state and completion/error decisions.
  always_comb begin
    p_state_n = p_state;
    good_n    = 1'b0;
    crcbad_n  = 1'b0;
    frame_n   = 1'b0;
    if (stop_err) begin
      if (p_state != P_HDR1) frame_n = 1'b1;
      p_state_n = P_HDR1;
    end else if (timeout_hit) begin
      frame_n   = 1'b1;
      p_state_n = P_HDR1;
    end else if (byte_valid) begin
      case (p_state)
        P_HDR1:  if (byte_data == 8'hFF) p_state_n = P_HDR2;
        P_HDR2:  p_state_n = (byte_data == 8'hFF) ? P_HDR3 : P_HDR1;
        P_HDR3: begin
          if (byte_data == 8'hFD)      p_state_n = P_RSV;
          else if (byte_data != 8'hFF) p_state_n = P_HDR1;
        end
        P_RSV:   p_state_n = (byte_data == 8'h00) ? P_ID : P_HDR1;
        P_ID:    p_state_n = P_LEN_L;
        P_LEN_L: p_state_n = P_LEN_H;
        P_LEN_H: begin
          if (len_full < 16'd4 || len_full > MAX_LEN) begin
            frame_n   = 1'b1;
            p_state_n = P_HDR1;
          end else begin
            p_state_n = P_INST;
          end
        end
        // Anything but 0x55 is our own instruction echoing back.
        P_INST:  p_state_n = (byte_data == 8'h55) ? P_ERR : P_HDR1;
        P_ERR:   p_state_n = (len > 16'd4) ? P_PARAM : P_CRC_L;
        P_PARAM: if (remain == 16'd1) p_state_n = P_CRC_L;
        P_CRC_L: p_state_n = P_CRC_H;
        P_CRC_H: begin
          if ({byte_data, crc_lo} == crc) good_n = 1'b1;
          else                            crcbad_n = 1'b1;
          p_state_n = P_HDR1;
        end
        default: p_state_n = P_HDR1;
      endcase
    end
  end

  // Inter-byte gap counter, only running inside a packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              to_cnt <= 32'd0;
    else if (p_state == P_HDR1 || byte_valid) to_cnt <= 32'd0;
    else                                    to_cnt <= to_cnt + 32'd1;
  end

  // Field capture, CRC accumulation and parameter destuffing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_l  <= 8'd0;
      len    <= 16'd0;
      id_l   <= 8'd0;
      err_l  <= 8'd0;
      crc_lo <= 8'd0;
      crc    <= 16'd0;
      remain <= 16'd0;
      plen_l <= 16'd0;
      data_l <= 32'd0;
      hist   <= 24'd0;
    end else if (byte_valid) begin
      case (p_state)
        P_HDR1: if (byte_data == 8'hFF) crc <= crc_byte(16'h0000, 8'hFF);
        // Extra FF in HDR3: the header really starts at the last two FFs.
        P_HDR3: crc <= (byte_data == 8'hFF) ? crc_byte(crc_byte(16'h0000, 8'hFF), 8'hFF)
                                            : crc_byte(crc, byte_data);
        P_ID: begin
          id_l <= byte_data;
          crc  <= crc_byte(crc, byte_data);
        end
        P_LEN_L: begin
          len_l <= byte_data;
          crc   <= crc_byte(crc, byte_data);
        end
        P_LEN_H: begin
          len <= len_full;
          crc <= crc_byte(crc, byte_data);
        end
        P_ERR: begin
          err_l  <= byte_data;
          remain <= len - 16'd4;
          plen_l <= 16'd0;
          data_l <= 32'd0;
          hist   <= 24'd0;
          crc    <= crc_byte(crc, byte_data);
        end
        P_PARAM: begin
          remain <= remain - 16'd1;
          hist   <= {hist[15:0], byte_data};
          crc    <= crc_byte(crc, byte_data);
          if (!is_stuff) begin
            plen_l <= plen_l + 16'd1;
            if (plen_l < 16'd4) data_l[{plen_l[1:0], 3'b000} +: 8] <= byte_data;
          end
        end
        P_CRC_L: crc_lo <= byte_data;
        P_CRC_H: crc_lo <= crc_lo;
        default: crc <= crc_byte(crc, byte_data);
      endcase
    end
  end

  // Output strobes and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_valid     <= 1'b0;
      crc_error        <= 1'b0;
      frame_error      <= 1'b0;
      status_id        <= 8'd0;
      status_error     <= 8'd0;
      status_param_len <= 16'd0;
      status_data      <= 32'd0;
    end else begin
      status_valid <= good_n;
      crc_error    <= crcbad_n;
      frame_error  <= frame_n;
      if (good_n) begin
        status_id        <= id_l;
        status_error     <= err_l;
        status_param_len <= plen_l;
        status_data      <= data_l;
      end
    end
  end

endmodule

// File: tb/tb_dynamixel_status_receiver.sv
// Bench for dynamixel_status_receiver: drives UART bytes onto rx, builds
// status packets (stuffing + CRC) from plain parameter lists and compares
// every strobe, with the result fields, against an expected queue.
module tb_dynamixel_status_receiver;

  localparam int CPB = 3;
  localparam int TO_BITS = 40;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        status_valid;
  logic [7:0]  status_id;
  logic [7:0]  status_error;
  logic [15:0] status_param_len;
  logic [31:0] status_data;
  logic        crc_error;
  logic        frame_error;
  logic        busy;

  always #5 clock = ~clock;

  dynamixel_status_receiver #(
    .clocks_per_bit(CPB),
    .max_length(64),
    .timeout_bits(TO_BITS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .status_valid(status_valid),
    .status_id(status_id),
    .status_error(status_error),
    .status_param_len(status_param_len),
    .status_data(status_data),
    .crc_error(crc_error),
    .frame_error(frame_error),
    .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];
  logic [65:0] act_q[$];
  logic [7:0]  pkt_q[$];
  logic [7:0]  prm_q[$];
  logic [7:0]  m_id;
  logic [7:0]  m_err;
  logic [15:0] m_plen;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Event word: kind (1 valid, 2 crc, 3 frame, 0 overlap) + result fields.
  function automatic logic [65:0] ev(input logic [1:0] k);
    return {k, m_id, m_err, m_plen, m_data};
  endfunction

  always @(negedge clock) begin : monitor
    int n;
    n = int'(status_valid) + int'(crc_error) + int'(frame_error);
    if (!reset && n != 0) begin
      if (n > 1)             act_q.push_back(66'd0);
      else if (status_valid) act_q.push_back({2'd1, status_id, status_error, status_param_len, status_data});
      else if (crc_error)    act_q.push_back({2'd2, status_id, status_error, status_param_len, status_data});
      else                   act_q.push_back({2'd3, status_id, status_error, status_param_len, status_data});
    end
  end

  task automatic drain(input string tag);
    check({tag, "_count"}, 66'(act_q.size()), 66'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) check(tag, act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  // CRC-16 over the first n bytes of pkt_q, one message bit at a time.
  function automatic logic [15:0] crc16_of(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ pkt_q[i][b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    return c;
  endfunction

  function automatic void add_crc();
    logic [15:0] c;
    c = crc16_of(pkt_q.size());
    pkt_q.push_back(c[7:0]);
    pkt_q.push_back(c[15:8]);
  endfunction

  // Build a status packet from prm_q into pkt_q and queue its expected event.
  task automatic build_status(input logic [7:0] id, input logic [7:0] err, input bit corrupt);
    logic [7:0]  st[$];
    logic [15:0] len;
    logic [15:0] c;
    int n;
    st = {};
    foreach (prm_q[i]) begin
      st.push_back(prm_q[i]);
      n = st.size();
      if (n >= 3 && st[n-3] == 8'hFF && st[n-2] == 8'hFF && st[n-1] == 8'hFD) st.push_back(8'hFD);
    end
    len = 16'(st.size() + 4);
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, id, len[7:0], len[15:8], 8'h55, err};
    foreach (st[i]) pkt_q.push_back(st[i]);
    c = crc16_of(pkt_q.size());
    if (corrupt) c = c ^ 16'($urandom_range(1, 65535));
    pkt_q.push_back(c[7:0]);
    pkt_q.push_back(c[15:8]);
    if (!corrupt) begin
      m_id   = id;
      m_err  = err;
      m_plen = 16'(prm_q.size());
      m_data = 32'd0;
      for (int i = 0; i < 4 && i < prm_q.size(); i++) m_data[8*i +: 8] = prm_q[i];
      exp_q.push_back(ev(2'd1));
    end else begin
      exp_q.push_back(ev(2'd2));
    end
  endtask

  task automatic rand_params(input int n);
    prm_q = {};
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: prm_q.push_back(8'hFF);
        1: prm_q.push_back(8'hFD);
        2: prm_q.push_back(8'h00);
        default: prm_q.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic send_pkt();
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clock);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    rx = 1'b1;
    m_id = 8'd0; m_err = 8'd0; m_plen = 16'd0; m_data = 32'd0;
    repeat (4) @(negedge clock);
    check("reset_fields", {status_id, status_error, status_param_len, status_data}, 66'd0);
    check("reset_strobes", {busy, status_valid, crc_error, frame_error}, 66'd0);
    reset = 1'b0;
    idle_bits(2);

    // Reference ping status packet.
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
    m_id = 8'h01; m_err = 8'h00; m_plen = 16'd3; m_data = 32'h00260406;
    exp_q.push_back(ev(2'd1));
    send_pkt();
    idle_bits(3);
    drain("ping");

    // Same packet with a bad CRC byte: crc_error, fields unchanged.
    pkt_q[13] = 8'h5C;
    exp_q.push_back(ev(2'd2));
    send_pkt();
    idle_bits(3);
    drain("ping_badcrc");

    // Echo of our own sync-write immediately followed by a status packet.
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE, 8'h09, 8'h00, 8'h83, 8'h40, 8'h00, 8'h01, 8'h00, 8'h84, 8'h00};
    add_crc();
    send_pkt();
    rand_params(2);
    build_status(8'h03, 8'h00, 1'b0);
    send_pkt();
    idle_bits(3);
    drain("echo_then_status");

    // Stuffed parameters: FF FF FD (FD) 12 -> 5 raw, 4 destuffed.
    prm_q = '{8'hFF, 8'hFF, 8'hFD, 8'h12};
    build_status(8'h07, 8'h80, 1'b0);
    send_pkt();
    idle_bits(3);
    drain("stuffing");

    // Stop bit low in the ID byte, then a clean packet.
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00};
    send_pkt();
    send_byte(8'h01, 1'b0);
    exp_q.push_back(ev(2'd3));
    idle_bits(2);
    rand_params(3);
    build_status(8'h11, 8'h00, 1'b0);
    send_pkt();
    idle_bits(3);
    drain("stop_error");

    // Packet stalls after ERR: timeout frame_error, busy drops.
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00};
    send_pkt();
    repeat (2) @(negedge clock);
    check("busy_mid_packet", 66'(busy), 66'd1);
    exp_q.push_back(ev(2'd3));
    idle_bits(TO_BITS + 1);
    repeat (4) @(negedge clock);
    check("busy_after_timeout", 66'(busy), 66'd0);
    drain("timeout");

    // Reset in the middle of PARAM: everything discarded, no strobes.
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h02, 8'h08, 8'h00, 8'h55, 8'h00, 8'h11, 8'h22};
    send_pkt();
    rx = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    m_id = 8'd0; m_err = 8'd0; m_plen = 16'd0; m_data = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_mid_busy", 66'(busy), 66'd0);
    check("reset_mid_fields", {status_id, status_error, status_param_len, status_data}, ev(2'd0));
    rx = 1'b1;
    reset = 1'b0;
    idle_bits(4);
    drain("reset_mid_param");

    // LEN = 3 is rejected at LEN_H.
    pkt_q = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00};
    exp_q.push_back(ev(2'd3));
    send_pkt();
    idle_bits(3);
    drain("len_short");

    // Noise FF before the header.
    rand_params(4);
    build_status(8'h21, 8'h01, 1'b0);
    pkt_q.push_front(8'hFF);
    send_pkt();
    idle_bits(3);
    drain("noise_header");

    // Randomized back-to-back status packets, some with corrupted CRC.
    for (int k = 0; k < 40; k++) begin
      rand_params($urandom_range(0, 8));
      build_status(8'($urandom_range(0, 252)), 8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
      send_pkt();
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(3);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
